// File: rtl/detector_jogada_pkg.sv
// Shared definitions for detector_jogada: state encoding, counter sizing and one-hot reduction.
package detector_jogada_pkg;

  typedef enum logic [2:0] {
    ESPERA       = 3'd0,
    FILTRA_PRESS = 3'd1,
    PULSO        = 3'd2,
    SEGURA       = 3'd3,
    FILTRA_SOLTA = 3'd4
  } estado_t;

  localparam int MAX_BOTOES = 32;

  function automatic int largura_cnt(input int ciclos);
    return ($clog2(ciclos) < 1) ? 1 : $clog2(ciclos);
  endfunction

  // Isolates the lowest-index set bit (two's-complement trick).
  function automatic logic [MAX_BOTOES-1:0] menor_bit(input logic [MAX_BOTOES-1:0] v);
    return v & (~v + MAX_BOTOES'(1));
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// Two-flop synchroniser bringing asynchronous button levels into the clock domain.
module sincronizador #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d_i,
  output logic [LARGURA-1:0] q_o
);

  logic [LARGURA-1:0] meta_q;
  logic [LARGURA-1:0] sync_q;

  // NOTE: non-blocking assignments make both flops sample pre-edge values, forming a real two-stage chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounced play detector: one-cycle jogada pulse plus one-hot jogada_valor per push-and-release.
// Build option DETECTOR_JOGADA_REJEITA_MULTIPLA_EN rejects multi-button presses instead of reducing them.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                jogada,
  output logic [N_BOTOES-1:0] jogada_valor,
  output logic                botao_ativo,
  output logic [2:0]          db_estado
);

  localparam int            CW      = largura_cnt(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] s;
  estado_t             estado_q, estado_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_BOTOES-1:0] amostra_q, amostra_d;
  logic [N_BOTOES-1:0] valor_q, valor_d;
  logic                jogada_q, ativo_q;

  sincronizador #(.LARGURA(N_BOTOES)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d_i   (botoes),
    .q_o   (s)
  );

`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
  logic amostra_multipla;
  assign amostra_multipla = (amostra_q & (amostra_q - N_BOTOES'(1))) != '0;
`else
  logic [N_BOTOES-1:0] amostra_unica;
  assign amostra_unica = N_BOTOES'(menor_bit(MAX_BOTOES'(amostra_q)));
`endif

  // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    amostra_d = amostra_q;
    valor_d   = valor_q;
    case (estado_q)
      ESPERA: begin
        if (s != '0) begin
          estado_d  = FILTRA_PRESS;
          amostra_d = s;
          cnt_d     = '0;
        end
      end
      FILTRA_PRESS: begin
        if (s != amostra_q) begin
          estado_d = ESPERA;
          cnt_d    = '0;
        end else if (cnt_q == CNT_FIM) begin
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
          if (amostra_multipla) begin
            estado_d = SEGURA;
          end else begin
            estado_d = PULSO;
            valor_d  = amostra_q;
          end
`else
          estado_d = PULSO;
          valor_d  = amostra_unica;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PULSO: estado_d = SEGURA;
      SEGURA: begin
        // Button changes while held are deliberately ignored; only a full release matters.
        if (s == '0) begin
          estado_d = FILTRA_SOLTA;
          cnt_d    = '0;
        end
      end
      FILTRA_SOLTA: begin
        if (s != '0)             estado_d = SEGURA;
        else if (cnt_q == CNT_FIM) estado_d = ESPERA;
        else                       cnt_d    = cnt_q + CW'(1);
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= ESPERA;
      cnt_q     <= '0;
      amostra_q <= '0;
      valor_q   <= '0;
      jogada_q  <= 1'b0;
      ativo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      amostra_q <= amostra_d;
      valor_q   <= valor_d;
      jogada_q  <= (estado_d == PULSO);
      ativo_q   <= (estado_d inside {PULSO, SEGURA, FILTRA_SOLTA});
    end
  end

  assign jogada       = jogada_q;
  assign jogada_valor = valor_q;
  assign botao_ativo  = ativo_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with a pulse scoreboard (N_BOTOES=4, DEBOUNCE_CICLOS=4).
module tb_detector_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       jogada;
  logic [3:0] jogada_valor;
  logic       botao_ativo;
  logic [2:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         ciclo;
    logic [3:0] valor;
  } pulso_t;

  pulso_t fila[$];
  pulso_t esp;

  detector_jogada #(.N_BOTOES(4), .DEBOUNCE_CICLOS(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes       (botoes),
    .jogada       (jogada),
    .jogada_valor (jogada_valor),
    .botao_ativo  (botao_ativo),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the rising edge that starts cycle c.
  task automatic ir_para(input int c);
    do begin @(posedge clock); #1; end while (cyc < c);
  endtask

  // Advance to the falling edge inside cycle c.
  task automatic amostra_em(input int c);
    do @(negedge clock); while (cyc < c);
  endtask

  // Every pulse must match the oldest expected entry in both cycle and value.
  always @(negedge clock) begin
    if (jogada !== 1'b0) begin
      if (fila.size() == 0) begin
        check("pulso_inesperado", 32'(jogada), 32'd0);
      end else begin
        esp = fila.pop_front();
        check("pulso_ciclo", cyc, esp.ciclo);
        check("pulso_valor", 32'(jogada_valor), 32'(esp.valor));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a, r, b, c, d, e, f, g;
    reset  = 1'b1;
    botoes = 4'b0000;
    repeat (3) @(negedge clock);
    check("rst_jogada", 32'(jogada), 32'd0);
    check("rst_valor",  32'(jogada_valor), 32'd0);
    check("rst_ativo",  32'(botao_ativo), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    ir_para(4);
    reset = 1'b0;

    // Clean press, held 20 cycles, then released.
    a = cyc + 2;
    ir_para(a); botoes = 4'b0010; fila.push_back('{ciclo: a + 7, valor: 4'b0010});
    amostra_em(a + 8);
    check("limpo_ativo",  32'(botao_ativo), 32'd1);
    check("limpo_estado", 32'(db_estado), 32'd3);
    check("limpo_valor",  32'(jogada_valor), 32'h2);
    r = a + 20;
    ir_para(r); botoes = 4'b0000;
    amostra_em(r + 6);
    check("solta_estado4", 32'(db_estado), 32'd4);
    check("solta_ativo1",  32'(botao_ativo), 32'd1);
    amostra_em(r + 7);
    check("solta_espera", 32'(db_estado), 32'd0);
    check("solta_ativo0", 32'(botao_ativo), 32'd0);

    // Press bounce: 3 high, 1 low, then stable.
    b = r + 10;
    ir_para(b);     botoes = 4'b0100;
    ir_para(b + 3); botoes = 4'b0000;
    ir_para(b + 4); botoes = 4'b0100; fila.push_back('{ciclo: b + 11, valor: 4'b0100});
    amostra_em(b + 10);
    check("ressalto_filtra", 32'(db_estado), 32'd1);
    amostra_em(b + 12);
    check("ressalto_valor",  32'(jogada_valor), 32'h4);
    check("ressalto_segura", 32'(db_estado), 32'd3);

    // Release bounce while held: off/on at 2-cycle intervals, then off.
    c = b + 14;
    ir_para(c);     botoes = 4'b0000;
    ir_para(c + 2); botoes = 4'b0100;
    ir_para(c + 4); botoes = 4'b0000;
    amostra_em(c + 5);
    check("solta_ressalto_segura", 32'(db_estado), 32'd3);
    ir_para(c + 6); botoes = 4'b0100;
    ir_para(c + 8); botoes = 4'b0000;
    amostra_em(c + 14);
    check("solta_ressalto_filtra", 32'(db_estado), 32'd4);
    amostra_em(c + 15);
    check("solta_ressalto_espera", 32'(db_estado), 32'd0);
    check("solta_ressalto_valor",  32'(jogada_valor), 32'h4);

    // Simultaneous two-button press.
    d = c + 17;
    ir_para(d); botoes = 4'b1010;
`ifndef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
    fila.push_back('{ciclo: d + 7, valor: 4'b0010});
`endif
    amostra_em(d + 8);
    check("multi_estado", 32'(db_estado), 32'd3);
    check("multi_ativo",  32'(botao_ativo), 32'd1);
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
    check("multi_valor", 32'(jogada_valor), 32'h4);
`else
    check("multi_valor", 32'(jogada_valor), 32'h2);
`endif
    ir_para(d + 10); botoes = 4'b0000;
    amostra_em(d + 17);
    check("multi_espera", 32'(db_estado), 32'd0);

    // Button change while held is ignored.
    e = d + 19;
    ir_para(e); botoes = 4'b0001; fila.push_back('{ciclo: e + 7, valor: 4'b0001});
    ir_para(e + 10); botoes = 4'b1000;
    amostra_em(e + 15);
    check("troca_estado", 32'(db_estado), 32'd3);
    check("troca_valor",  32'(jogada_valor), 32'h1);
    ir_para(e + 16); botoes = 4'b0000;
    amostra_em(e + 23);
    check("troca_espera", 32'(db_estado), 32'd0);

    // Reset during press filtering (cnt=2), button still held afterwards.
    f = e + 25;
    ir_para(f); botoes = 4'b0001;
    amostra_em(f + 5);
    check("pre_reset_filtra", 32'(db_estado), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_jogada", 32'(jogada), 32'd0);
    check("reset_valor",  32'(jogada_valor), 32'd0);
    check("reset_ativo",  32'(botao_ativo), 32'd0);
    check("reset_estado", 32'(db_estado), 32'd0);
    g = f + 8;
    ir_para(g); reset = 1'b0; fila.push_back('{ciclo: g + 7, valor: 4'b0001});
    amostra_em(g + 8);
    check("pos_reset_segura", 32'(db_estado), 32'd3);
    ir_para(g + 9); botoes = 4'b0000;
    amostra_em(g + 16);
    check("pos_reset_espera", 32'(db_estado), 32'd0);

    check("fila_vazia", 32'(fila.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
